fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of `decoder`. It holds the fetch PC and issues single-outstanding word reads to instruction memory. Returned words are buffered in a small FIFO and presented to the decoder's `DataInst` input with a valid/ready handshake. A redirect from the execute stage flushes the buffer and discards any in-flight response.

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, decoder handshake and redirect input.
// master = fetch_unit, slave = memory/decoder/execute side.
interface fetch_unit_if;
    logic        En;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemAck;
    logic [31:0] MemRdata;
    logic [31:0] DataInst;
    logic [31:0] InstPc;
    logic        InstValid;
    logic        InstReady;
    logic        Redirect;
    logic [31:0] RedirectPc;
    logic        FetchFault;

    modport master (
        input  En, MemAck, MemRdata, InstReady, Redirect, RedirectPc,
        output MemReq, MemAddr, DataInst, InstPc, InstValid, FetchFault
    );

    modport slave (
        output En, MemAck, MemRdata, InstReady, Redirect, RedirectPc,
        input  MemReq, MemAddr, DataInst, InstPc, InstValid, FetchFault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding word reads into a circular buffer feeding the decoder.
// Define FETCH_ALIGN_CHECK_EN to fault on misaligned redirects instead of forcing alignment.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input logic          Clk,
    input logic          RstN,
    fetch_unit_if.master bus
);
    localparam int unsigned    PTR_W   = $clog2(BUF_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = BUF_DEPTH[PTR_W:0];
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       stateQ, stateD;
    logic [31:0]      memAddrQ, memAddrD;
    logic [31:0]      flushPcQ, flushPcD;
    logic [31:0]      nextPc, target;
    logic             faultQ, faultD;
    logic [PTR_W:0]   countQ, countD;
    logic [PTR_W-1:0] rdPtrQ, rdPtrD, wrPtrQ, wrPtrD;
    logic [31:0]      dataMem [BUF_DEPTH];
    logic [31:0]      pcMem   [BUF_DEPTH];
    logic             pop, push, pending, issue;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target = bus.RedirectPc;
    assign faultD = bus.Redirect ? (bus.RedirectPc[1:0] != 2'b00) : faultQ;
`else
    assign target = {bus.RedirectPc[31:2], 2'b00};
    assign faultD = 1'b0;
`endif

    assign pop     = (countQ != '0) && bus.InstReady;
    // A redirect discards a coincident response, so it never reaches the buffer.
    assign push    = bus.MemAck && (stateQ == REQ) && !bus.Redirect;
    assign pending = (stateQ != IDLE) && !bus.MemAck;

    always_comb begin
        rdPtrD = rdPtrQ;
        wrPtrD = wrPtrQ;
        countD = countQ;
        if (bus.Redirect) begin
            rdPtrD = '0;
            wrPtrD = '0;
            countD = '0;
        end else begin
            if (push) wrPtrD = wrPtrQ + 1'b1;
            if (pop)  rdPtrD = rdPtrQ + 1'b1;
            case ({push, pop})
                2'b10:   countD = countQ + 1'b1;
                2'b01:   countD = countQ - 1'b1;
                default: countD = countQ;
            endcase
        end
    end

    always_comb begin
        nextPc   = memAddrQ;
        flushPcD = flushPcQ;
        if (bus.Redirect) begin
            nextPc   = target;
            flushPcD = target;
        end else if (bus.MemAck && (stateQ == REQ)) begin
            nextPc = memAddrQ + 32'd4;
        end else if (bus.MemAck && (stateQ == FLUSH)) begin
            nextPc = flushPcQ;
        end

        issue = bus.En && !faultD && !pending && (countD < DEPTH_C);

        // An outstanding request keeps its address until acked; a redirect only retargets.
        if (pending) begin
            memAddrD = memAddrQ;
            stateD   = (bus.Redirect || (stateQ == FLUSH)) ? FLUSH : REQ;
        end else begin
            memAddrD = nextPc;
            stateD   = issue ? REQ : IDLE;
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            stateQ   <= IDLE;
            memAddrQ <= RESET_PC;
            flushPcQ <= RESET_PC;
            faultQ   <= 1'b0;
            countQ   <= '0;
            rdPtrQ   <= '0;
            wrPtrQ   <= '0;
        end else begin
            stateQ   <= stateD;
            memAddrQ <= memAddrD;
            flushPcQ <= flushPcD;
            faultQ   <= faultD;
            countQ   <= countD;
            rdPtrQ   <= rdPtrD;
            wrPtrQ   <= wrPtrD;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            dataMem[wrPtrQ] <= bus.MemRdata;
            pcMem[wrPtrQ]   <= memAddrQ;
        end
    end

    assign bus.MemReq     = (stateQ != IDLE);
    assign bus.MemAddr    = memAddrQ;
    assign bus.InstValid  = (countQ != '0);
    assign bus.DataInst   = (countQ != '0) ? dataMem[rdPtrQ] : NOP;
    assign bus.InstPc     = (countQ != '0) ? pcMem[rdPtrQ] : 32'h0000_0000;
    assign bus.FetchFault = faultQ;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected words, a monitor checks transfers.
module tb_fetch_unit;
    logic Clk;
    logic RstN;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC  (32'h0000_0100),
        .BUF_DEPTH (2)
    ) dut (
        .Clk  (Clk),
        .RstN (RstN),
        .bus  (bus)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   ackDelay = 0;
    int   waitCnt = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pushExp(input logic [31:0] pc, input logic [31:0] data);
        ent_t e;
        e.pc   = pc;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Advance to the next falling edge and play the memory side for that cycle.
    task automatic tick();
        @(negedge Clk);
        if (bus.MemReq) begin
            if (waitCnt >= ackDelay) begin
                bus.MemAck   = 1'b1;
                bus.MemRdata = {16'hC0DE, bus.MemAddr[15:0]};
                waitCnt      = 0;
            end else begin
                bus.MemAck = 1'b0;
                waitCnt++;
            end
        end else begin
            bus.MemAck = 1'b0;
            waitCnt    = 0;
        end
        bus.Redirect = 1'b0;
    endtask

    task automatic startPhase();
        RstN           = 1'b0;
        bus.En         = 1'b0;
        bus.MemAck     = 1'b0;
        bus.MemRdata   = 32'h0;
        bus.InstReady  = 1'b1;
        bus.Redirect   = 1'b0;
        bus.RedirectPc = 32'h0;
        ackDelay       = 0;
        waitCnt        = 0;
        repeat (2) @(negedge Clk);
        expQ.delete();
    endtask

    task automatic drain(input string name);
        logic idle;
        bus.En = 1'b0;
        idle   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.MemReq && !bus.InstValid) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_drained"}, {31'h0, idle}, 32'h1);
        chk({name, "_leftover"}, expQ.size(), 32'h0);
    endtask

    initial begin
        ent_t e;
        forever begin
            @(negedge Clk);
            #3;
            if (RstN && bus.InstValid && bus.InstReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_inst: got pc %h data %h, required none",
                             bus.InstPc, bus.DataInst);
                end else begin
                    e = expQ.pop_front();
                    chk("inst_pc", bus.InstPc, e.pc);
                    chk("inst_data", bus.DataInst, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and zero-wait streaming.
        startPhase();
        chk("rst_memreq", {31'h0, bus.MemReq}, 32'h0);
        chk("rst_memaddr", bus.MemAddr, 32'h100);
        chk("rst_valid", {31'h0, bus.InstValid}, 32'h0);
        chk("rst_datainst", bus.DataInst, 32'h13);
        chk("rst_instpc", bus.InstPc, 32'h0);
        chk("rst_fault", {31'h0, bus.FetchFault}, 32'h0);
        RstN   = 1'b1;
        bus.En = 1'b1;
        pushExp(32'h100, 32'hC0DE0100);
        pushExp(32'h104, 32'hC0DE0104);
        pushExp(32'h108, 32'hC0DE0108);
        tick();
        chk("stream_addr0", bus.MemAddr, 32'h100);
        chk("stream_req0", {31'h0, bus.MemReq}, 32'h1);
        tick();
        chk("stream_addr1", bus.MemAddr, 32'h104);
        chk("stream_valid1", {31'h0, bus.InstValid}, 32'h1);
        tick();
        chk("stream_addr2", bus.MemAddr, 32'h108);
        chk("stream_pc2", bus.InstPc, 32'h104);
        bus.En = 1'b0;
        drain("stream");

        // Backpressure: buffer fills, requests stop, nothing lost.
        startPhase();
        RstN          = 1'b1;
        bus.En        = 1'b1;
        bus.InstReady = 1'b0;
        pushExp(32'h100, 32'hC0DE0100);
        pushExp(32'h104, 32'hC0DE0104);
        pushExp(32'h108, 32'hC0DE0108);
        tick();
        tick();
        tick();
        chk("bp_req_drop", {31'h0, bus.MemReq}, 32'h0);
        chk("bp_head_pc", bus.InstPc, 32'h100);
        repeat (3) tick();
        chk("bp_req_still_low", {31'h0, bus.MemReq}, 32'h0);
        chk("bp_valid", {31'h0, bus.InstValid}, 32'h1);
        tick();
        bus.InstReady = 1'b1;
        tick();
        chk("bp_resume_addr", bus.MemAddr, 32'h108);
        chk("bp_resume_req", {31'h0, bus.MemReq}, 32'h1);
        bus.En = 1'b0;
        drain("bp");

        // Redirect while a slow request is outstanding: response dropped.
        startPhase();
        RstN   = 1'b1;
        bus.En = 1'b1;
        pushExp(32'h100, 32'hC0DE0100);
        pushExp(32'h104, 32'hC0DE0104);
        pushExp(32'h200, 32'hC0DE0200);
        tick();
        tick();
        ackDelay = 3;
        tick();
        chk("flush_req_addr", bus.MemAddr, 32'h108);
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h200;
        tick();
        chk("flush_valid", {31'h0, bus.InstValid}, 32'h0);
        chk("flush_held_addr", bus.MemAddr, 32'h108);
        chk("flush_held_req", {31'h0, bus.MemReq}, 32'h1);
        tick();
        tick();
        ackDelay = 0;
        tick();
        chk("flush_new_addr", bus.MemAddr, 32'h200);
        chk("flush_dropped", {31'h0, bus.InstValid}, 32'h0);
        bus.En = 1'b0;
        drain("flush");

        // Redirect coincident with ack and transfer.
        startPhase();
        RstN   = 1'b1;
        bus.En = 1'b1;
        pushExp(32'h100, 32'hC0DE0100);
        pushExp(32'h300, 32'hC0DE0300);
        tick();
        tick();
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h300;
        tick();
        chk("coinc_addr", bus.MemAddr, 32'h300);
        chk("coinc_req", {31'h0, bus.MemReq}, 32'h1);
        chk("coinc_valid", {31'h0, bus.InstValid}, 32'h0);
        bus.En = 1'b0;
        drain("coinc");

        // PC wrap at the top of the address space.
        startPhase();
        RstN           = 1'b1;
        bus.En         = 1'b1;
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'hFFFF_FFFC;
        pushExp(32'hFFFF_FFFC, 32'hC0DEFFFC);
        pushExp(32'h0000_0000, 32'hC0DE0000);
        tick();
        chk("wrap_addr_top", bus.MemAddr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr_zero", bus.MemAddr, 32'h0000_0000);
        bus.En = 1'b0;
        drain("wrap");

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect faults until an aligned one.
        startPhase();
        RstN           = 1'b1;
        bus.En         = 1'b1;
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h202;
        pushExp(32'h300, 32'hC0DE0300);
        tick();
        chk("align_fault_set", {31'h0, bus.FetchFault}, 32'h1);
        chk("align_no_req", {31'h0, bus.MemReq}, 32'h0);
        tick();
        chk("align_no_req2", {31'h0, bus.MemReq}, 32'h0);
        chk("align_fault_hold", {31'h0, bus.FetchFault}, 32'h1);
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h300;
        tick();
        chk("align_fault_clr", {31'h0, bus.FetchFault}, 32'h0);
        chk("align_resume_addr", bus.MemAddr, 32'h300);
        chk("align_resume_req", {31'h0, bus.MemReq}, 32'h1);
        bus.En = 1'b0;
        drain("align");
`else
        // Misaligned redirect target has its low bits forced to zero.
        startPhase();
        RstN           = 1'b1;
        bus.En         = 1'b1;
        bus.Redirect   = 1'b1;
        bus.RedirectPc = 32'h202;
        pushExp(32'h200, 32'hC0DE0200);
        tick();
        chk("align_forced_addr", bus.MemAddr, 32'h200);
        chk("align_no_fault", {31'h0, bus.FetchFault}, 32'h0);
        bus.En = 1'b0;
        drain("align");
`endif

        // Asynchronous reset in the middle of an outstanding request.
        startPhase();
        RstN     = 1'b1;
        bus.En   = 1'b1;
        ackDelay = 5;
        tick();
        tick();
        chk("arst_pre_req", {31'h0, bus.MemReq}, 32'h1);
        #2;
        RstN = 1'b0;
        #1;
        chk("arst_req", {31'h0, bus.MemReq}, 32'h0);
        chk("arst_addr", bus.MemAddr, 32'h100);
        chk("arst_valid", {31'h0, bus.InstValid}, 32'h0);
        startPhase();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
